// File: rtl/pulse_meter_pkg.sv
// Shared types and constants for the pulse width meter.
package pulse_meter_pkg;

   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      WAIT_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      MEASURE   = 2'd2,
      REPORT    = 2'd3
   } state_e;

endpackage

// File: rtl/pulse_meter_if.sv
// Result handshake between the pulse meter (master) and its consumer (slave).
interface pulse_meter_if #(
   parameter int WIDTH = pulse_meter_pkg::DEFAULT_WIDTH
) ();

   logic [WIDTH-1:0] width_out;
   logic             width_valid;
   logic             width_ready;
   logic             overflow;

   modport master (
      output width_out,
      output width_valid,
      output overflow,
      input  width_ready
   );

   modport slave (
      input  width_out,
      input  width_valid,
      input  overflow,
      output width_ready
   );

endinterface

// File: rtl/pulse_meter_sat_counter.sv
// Saturating up-counter with clear/load-one; sat latches when an increment hits the ceiling.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load_one,
   input  logic             inc,
   output logic [WIDTH-1:0] count,
   output logic             sat
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             sat_q, sat_d;

   always_comb begin
      count_d = count_q;
      sat_d   = sat_q;
      if (clear) begin
         count_d = '0;
         sat_d   = 1'b0;
      end else if (load_one) begin
         count_d = WIDTH'(1);
         sat_d   = 1'b0;
      end else if (inc) begin
         if (count_q == '1) begin
            sat_d = 1'b1;
         end else begin
            count_d = count_q + WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         sat_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         sat_q   <= sat_d;
      end
   end

   assign count = count_q;
   assign sat   = sat_q;

endmodule

// File: rtl/pulse_meter.sv
// Measures high-interval length of pulse_in and reports it over a valid/ready handshake.
// Optional PULSE_METER_MAX_EN adds a running maximum (max_width) with max_clear.
module pulse_meter
   import pulse_meter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             pulse_in,
   output logic             busy,
   output logic             missed,
`ifdef PULSE_METER_MAX_EN
   input  logic             max_clear,
   output logic [WIDTH-1:0] max_width,
`endif
   pulse_meter_if.master    meas
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] width_out_q, width_out_d;
   logic             width_valid_q, width_valid_d;
   logic             overflow_q, overflow_d;
   logic             busy_q, busy_d;
   logic             missed_q, missed_d;
   logic             pulse_prev_q;

   logic             cnt_clear, cnt_load, cnt_inc, capture;
   logic [WIDTH-1:0] count;
   logic             sat;

   sat_counter #(.WIDTH(WIDTH)) u_counter (
      .clk      (clk),
      .reset    (reset),
      .clear    (cnt_clear),
      .load_one (cnt_load),
      .inc      (cnt_inc),
      .count    (count),
      .sat      (sat)
   );

   always_comb begin
      state_d       = state_q;
      width_out_d   = width_out_q;
      width_valid_d = width_valid_q;
      overflow_d    = overflow_q;
      cnt_clear     = 1'b0;
      cnt_load      = 1'b0;
      cnt_inc       = 1'b0;
      capture       = 1'b0;
      case (state_q)
         // A pulse already high here must finish before we may arm on a fresh edge.
         WAIT_LOW: begin
            if (!pulse_in) state_d = WAIT_HIGH;
         end
         WAIT_HIGH: begin
            if (pulse_in) begin
               if (enable) begin
                  state_d  = MEASURE;
                  cnt_load = 1'b1;
               end else begin
                  state_d = WAIT_LOW;
               end
            end
         end
         MEASURE: begin
            if (pulse_in) begin
               cnt_inc = 1'b1;
            end else begin
               width_out_d   = count;
               overflow_d    = sat;
               width_valid_d = 1'b1;
               capture       = 1'b1;
               state_d       = REPORT;
            end
         end
         REPORT: begin
            if (width_valid_q && meas.width_ready) begin
               width_valid_d = 1'b0;
               overflow_d    = 1'b0;
               cnt_clear     = 1'b1;
               state_d       = pulse_in ? WAIT_LOW : WAIT_HIGH;
            end
         end
         default: state_d = WAIT_LOW;
      endcase
      busy_d   = (state_d == MEASURE);
      missed_d = (state_q == REPORT) && !pulse_prev_q && pulse_in;
   end

`ifdef PULSE_METER_MAX_EN
   logic [WIDTH-1:0] max_width_q, max_width_d;

   // Capture takes priority over a simultaneous clear.
   always_comb begin
      max_width_d = max_width_q;
      if (capture) begin
         if (count > max_width_q) max_width_d = count;
      end else if (max_clear) begin
         max_width_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) max_width_q <= '0;
      else       max_width_q <= max_width_d;
   end

   assign max_width = max_width_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= WAIT_LOW;
         width_out_q   <= '0;
         width_valid_q <= 1'b0;
         overflow_q    <= 1'b0;
         busy_q        <= 1'b0;
         missed_q      <= 1'b0;
         pulse_prev_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         width_out_q   <= width_out_d;
         width_valid_q <= width_valid_d;
         overflow_q    <= overflow_d;
         busy_q        <= busy_d;
         missed_q      <= missed_d;
         pulse_prev_q  <= pulse_in;
      end
   end

   assign meas.width_out   = width_out_q;
   assign meas.width_valid = width_valid_q;
   assign meas.overflow    = overflow_q;
   assign busy             = busy_q;
   assign missed           = missed_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: WIDTH=16 and WIDTH=4 instances on shared stimulus, checked every
// cycle against an integer-length reference model plus directed vector table and sequences.
module tb_pulse_meter;

   logic clk = 1'b0;
   logic rst, en, pin, rdy, mclr;
   logic busy16, missed16, busy4, missed4;
   logic [15:0] maxw16;
   logic [3:0]  maxw4;
   int total = 0;
   int bad = 0;
   bit chk_on = 1'b0;

   always #5 clk = ~clk;

   pulse_meter_if #(.WIDTH(16)) if16 ();
   pulse_meter_if #(.WIDTH(4))  if4 ();
   assign if16.width_ready = rdy;
   assign if4.width_ready  = rdy;

   pulse_meter #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(rst), .enable(en), .pulse_in(pin),
      .busy(busy16), .missed(missed16),
`ifdef PULSE_METER_MAX_EN
      .max_clear(mclr), .max_width(maxw16),
`endif
      .meas(if16)
   );

   pulse_meter #(.WIDTH(4)) dut4 (
      .clk(clk), .reset(rst), .enable(en), .pulse_in(pin),
      .busy(busy4), .missed(missed4),
`ifdef PULSE_METER_MAX_EN
      .max_clear(mclr), .max_width(maxw4),
`endif
      .meas(if4)
   );

`ifndef PULSE_METER_MAX_EN
   assign maxw16 = '0;
   assign maxw4  = '0;
`endif

   // Reference model: pulse lengths kept as unbounded integers, saturation applied on output.
   typedef struct {
      int run;
      int res;
      int maxw;
      bit measuring;
      bit pending;
      bit seen_low;
      bit prev;
      bit miss;
   } model_t;

   model_t m16, m4;

   function automatic int satv(int v, int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   function automatic model_t step(model_t m, bit r, bit e, bit p, bit rd, bit clr, int maxv);
      model_t n = m;
      bit captured = 1'b0;
      if (r) begin
         n = '{default: 0};
         return n;
      end
      n.miss = m.pending && !m.prev && p;
      if (m.measuring) begin
         if (p) n.run = m.run + 1;
         else begin
            n.measuring = 1'b0;
            n.pending   = 1'b1;
            n.res       = m.run;
            captured    = 1'b1;
            if (satv(m.run, maxv) > m.maxw) n.maxw = satv(m.run, maxv);
         end
      end else if (m.pending) begin
         if (rd) begin
            n.pending  = 1'b0;
            n.seen_low = !p;
         end
      end else if (!m.seen_low) begin
         if (!p) n.seen_low = 1'b1;
      end else if (p) begin
         if (e) begin
            n.measuring = 1'b1;
            n.run       = 1;
         end else begin
            n.seen_low = 1'b0;
         end
      end
      if (!captured && clr) n.maxw = 0;
      n.prev = p;
      return n;
   endfunction

   always @(posedge clk) begin
      m16 = step(m16, rst, en, pin, rdy, mclr, 65535);
      m4  = step(m4,  rst, en, pin, rdy, mclr, 15);
   end

   task automatic chk(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("m16_width", int'(if16.width_out), satv(m16.res, 65535));
         chk("m16_valid", int'(if16.width_valid), int'(m16.pending));
         chk("m16_ovf", int'(if16.overflow), int'(m16.pending && m16.res > 65535));
         chk("m16_busy", int'(busy16), int'(m16.measuring));
         chk("m16_missed", int'(missed16), int'(m16.miss));
         chk("m4_width", int'(if4.width_out), satv(m4.res, 15));
         chk("m4_valid", int'(if4.width_valid), int'(m4.pending));
         chk("m4_ovf", int'(if4.overflow), int'(m4.pending && m4.res > 15));
         chk("m4_busy", int'(busy4), int'(m4.measuring));
         chk("m4_missed", int'(missed4), int'(m4.miss));
`ifdef PULSE_METER_MAX_EN
         chk("m16_maxw", int'(maxw16), m16.maxw);
         chk("m4_maxw", int'(maxw4), m4.maxw);
`endif
      end
   end

   typedef struct {
      int len;
      bit en;
      bit valid;
      int w16;
      bit o16;
      int w4;
      bit o4;
   } vec_t;

   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one pulse with width_ready=1, then checks the single-cycle result.
   task automatic run_vec(vec_t v);
      int bc = 0;
      en  = v.en;
      pin = 1'b1;
      for (int i = 0; i < v.len; i++) begin
         cyc(1);
         if (busy16) bc++;
      end
      pin = 1'b0;
      cyc(1);
      chk($sformatf("vec%0d_valid", v.len), int'(if16.width_valid), int'(v.valid));
      if (v.valid) begin
         chk($sformatf("vec%0d_w16", v.len), int'(if16.width_out), v.w16);
         chk($sformatf("vec%0d_o16", v.len), int'(if16.overflow), int'(v.o16));
         chk($sformatf("vec%0d_w4", v.len), int'(if4.width_out), v.w4);
         chk($sformatf("vec%0d_o4", v.len), int'(if4.overflow), int'(v.o4));
         chk($sformatf("vec%0d_busycyc", v.len), bc, v.len);
      end
      cyc(1);
      chk($sformatf("vec%0d_valid_drop", v.len), int'(if16.width_valid), 0);
      cyc(2);
   endtask

   vec_t tbl[$];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1);
   end

   initial begin
      int vcnt, mcnt;
      rst = 1'b1; en = 1'b1; pin = 1'b0; rdy = 1'b1; mclr = 1'b0;
      cyc(1);
      chk_on = 1'b1;
      cyc(2);
      chk("rst_valid", int'(if16.width_valid), 0);
      chk("rst_width", int'(if16.width_out), 0);
      chk("rst_busy", int'(busy16), 0);
      rst = 1'b0;
      cyc(3);

      tbl.push_back('{len: 5,  en: 1, valid: 1, w16: 5,  o16: 0, w4: 5,  o4: 0});
      tbl.push_back('{len: 20, en: 1, valid: 1, w16: 20, o16: 0, w4: 15, o4: 1});
      tbl.push_back('{len: 3,  en: 1, valid: 1, w16: 3,  o16: 0, w4: 3,  o4: 0});
      tbl.push_back('{len: 1,  en: 1, valid: 1, w16: 1,  o16: 0, w4: 1,  o4: 0});
      tbl.push_back('{len: 15, en: 1, valid: 1, w16: 15, o16: 0, w4: 15, o4: 0});
      tbl.push_back('{len: 16, en: 1, valid: 1, w16: 16, o16: 0, w4: 15, o4: 1});
      tbl.push_back('{len: 6,  en: 0, valid: 0, w16: 0,  o16: 0, w4: 0,  o4: 0});
      foreach (tbl[i]) run_vec(tbl[i]);
      en = 1'b1;

      // Result held with width_ready low; a second pulse during REPORT is dropped.
      rdy = 1'b0;
      pin = 1'b1;
      cyc(7);
      pin = 1'b0;
      mcnt = 0;
      for (int i = 0; i < 12; i++) begin
         if (i == 2) pin = 1'b1;
         if (i == 4) pin = 1'b0;
         cyc(1);
         if (missed16) mcnt++;
      end
      chk("hold_width", int'(if16.width_out), 7);
      chk("hold_valid", int'(if16.width_valid), 1);
      chk("missed_count", mcnt, 1);
      rdy = 1'b1;
      cyc(1);
      vcnt = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         if (if16.width_valid) vcnt++;
      end
      chk("dropped_not_reported", vcnt, 0);

      // Enable raised mid-pulse must not start a measurement.
      en = 1'b0;
      pin = 1'b1;
      cyc(2);
      en = 1'b1;
      cyc(4);
      pin = 1'b0;
      vcnt = 0;
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         if (if16.width_valid) vcnt++;
      end
      chk("late_enable_no_result", vcnt, 0);
      run_vec('{len: 4, en: 1, valid: 1, w16: 4, o16: 0, w4: 4, o4: 0});

      // Pulse already high across reset release is ignored.
      rst = 1'b1;
      pin = 1'b1;
      cyc(2);
      rst = 1'b0;
      vcnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (i == 3) pin = 1'b0;
         cyc(1);
         if (if16.width_valid) vcnt++;
      end
      chk("high_at_release_no_result", vcnt, 0);
      run_vec('{len: 9, en: 1, valid: 1, w16: 9, o16: 0, w4: 9, o4: 0});

      // Reset in the middle of MEASURE.
      pin = 1'b1;
      cyc(4);
      chk("pre_reset_busy", int'(busy16), 1);
      rst = 1'b1;
      cyc(1);
      chk("mid_reset_valid", int'(if16.width_valid), 0);
      chk("mid_reset_busy", int'(busy16), 0);
      rst = 1'b0;
      cyc(2);
      pin = 1'b0;
      cyc(3);

`ifdef PULSE_METER_MAX_EN
      mclr = 1'b1;
      cyc(1);
      mclr = 1'b0;
      run_vec('{len: 3, en: 1, valid: 1, w16: 3, o16: 0, w4: 3, o4: 0});
      run_vec('{len: 8, en: 1, valid: 1, w16: 8, o16: 0, w4: 8, o4: 0});
      run_vec('{len: 5, en: 1, valid: 1, w16: 5, o16: 0, w4: 5, o4: 0});
      chk("max_after_3_8_5", int'(maxw16), 8);
      chk("max4_after_3_8_5", int'(maxw4), 8);
      mclr = 1'b1;
      cyc(1);
      mclr = 1'b0;
      chk("max_cleared", int'(maxw16), 0);
      run_vec('{len: 2, en: 1, valid: 1, w16: 2, o16: 0, w4: 2, o4: 0});
      chk("max_after_2", int'(maxw16), 2);
`endif

      // Randomized traffic; the per-cycle model comparison does the checking.
      for (int n = 0; n < 300; n++) begin
         int gap, len;
         gap = $urandom_range(6, 2);
         len = $urandom_range(22, 1);
         pin = 1'b0;
         for (int i = 0; i < gap; i++) begin
            rdy  = ($urandom_range(3, 0) != 0);
            mclr = ($urandom_range(15, 0) == 0);
            rst  = ($urandom_range(199, 0) == 0);
            cyc(1);
         end
         rst = 1'b0;
         en  = ($urandom_range(7, 0) != 0);
         pin = 1'b1;
         for (int i = 0; i < len; i++) begin
            rdy  = ($urandom_range(3, 0) != 0);
            mclr = ($urandom_range(15, 0) == 0);
            if ($urandom_range(9, 0) == 0) en = ~en;
            cyc(1);
         end
      end
      pin = 1'b0; rdy = 1'b1; mclr = 1'b0;
      cyc(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
